// File: rtl/alt_ddrx_fetch_pkg.sv
// Shared types and helpers for the DDRx command fetch sequencer.
package alt_ddrx_fetch_pkg;

  // Sequencer states: one load cycle (FETCH / ECC_FETCH) always precedes a stable slot.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH      = 3'd1,
    ACTIVE     = 3'd2,
    ECC_FETCH  = 3'd3,
    ECC_ACTIVE = 3'd4
  } fetch_state_e;

  // Popcount helper operates on a fixed-width input; callers zero-extend.
  localparam int POP_MAX_W = 32;
  localparam int POP_CNT_W = 6;

  function automatic logic [POP_CNT_W-1:0] popcount(input logic [POP_MAX_W-1:0] v);
    logic [POP_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      cnt = cnt + POP_CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  // Decision taken whenever the current slot is free to be refilled:
  // stall wins, then ECC, then a normal fetch, else stay idle.
  function automatic fetch_state_e next_decision(input logic stall,
                                                 input logic ecc_req,
                                                 input logic next_valid);
    if (stall) return IDLE;
    if (ecc_req) return ECC_FETCH;
    if (next_valid) return FETCH;
    return IDLE;
  endfunction

endpackage

// File: rtl/alt_ddrx_fetch_sequencer_if.sv
// Bundle of queue / issue-FSM / ECC signals seen by the fetch sequencer.
interface alt_ddrx_fetch_sequencer_if #(
  parameter int CTL_CMD_QUEUE_DEPTH = 8,
  parameter int CNT_WIDTH           = 16
);
  import alt_ddrx_fetch_pkg::*;

  localparam int CMD_CNT_W = $clog2(CTL_CMD_QUEUE_DEPTH + 2);

  logic [CTL_CMD_QUEUE_DEPTH:0] cmd_is_valid;
  logic                         sm_cmd_done;
  logic                         stall_fetch;
  logic                         ecc_err_req;
  logic                         fetch;
  logic                         ecc_fetch_error_addr;
  logic                         ecc_err_ack;
  logic                         current_valid;
  logic                         ecc_active;
  logic [CMD_CNT_W-1:0]         cmd_count;
  logic [CNT_WIDTH-1:0]         fetch_count;
  logic                         err_unexpected_done;

  // Sequencer side.
  modport slave (
    input  cmd_is_valid, sm_cmd_done, stall_fetch, ecc_err_req,
    output fetch, ecc_fetch_error_addr, ecc_err_ack, current_valid,
           ecc_active, cmd_count, fetch_count, err_unexpected_done
  );

  // Environment side (queue, issue FSM, ECC).
  modport master (
    output cmd_is_valid, sm_cmd_done, stall_fetch, ecc_err_req,
    input  fetch, ecc_fetch_error_addr, ecc_err_ack, current_valid,
           ecc_active, cmd_count, fetch_count, err_unexpected_done
  );

endinterface

// File: rtl/alt_ddrx_fetch_sequencer.sv
// Decides when the current command slot is retired and refilled, and when
// the ECC error-address command is inserted. Moore outputs from registers.
module alt_ddrx_fetch_sequencer
  import alt_ddrx_fetch_pkg::*;
#(
  parameter int CTL_CMD_QUEUE_DEPTH = 8,
  parameter int CNT_WIDTH           = 16
) (
  input  logic                        ctl_clk,
  input  logic                        ctl_reset_n,
  alt_ddrx_fetch_sequencer_if.slave   seq_bus
);

  localparam int CMD_CNT_W = $clog2(CTL_CMD_QUEUE_DEPTH + 2);

  fetch_state_e         state_q, state_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ecc_req_eff;
  logic                 slot_busy;

  // While the ack pulse is out the ECC block has not yet dropped its request;
  // masking it here keeps the same request from being serviced twice.
  assign ecc_req_eff = seq_bus.ecc_err_req & ~ack_q;
  assign slot_busy   = (state_q == ACTIVE) || (state_q == ECC_ACTIVE);

  // Next-state, ack pulse, sticky error and fetch counter.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = err_q | (seq_bus.sm_cmd_done & ~slot_busy);
    cnt_d   = (state_q == FETCH) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    unique case (state_q)
      IDLE: begin
        state_d = next_decision(seq_bus.stall_fetch, ecc_req_eff,
                                seq_bus.cmd_is_valid[1]);
      end
      FETCH:     state_d = ACTIVE;
      ECC_FETCH: state_d = ECC_ACTIVE;
      ACTIVE: begin
        if (seq_bus.sm_cmd_done) begin
          state_d = next_decision(seq_bus.stall_fetch, ecc_req_eff,
                                  seq_bus.cmd_is_valid[1]);
        end
      end
      ECC_ACTIVE: begin
        // The request that produced this command is still high; ignore it.
        if (seq_bus.sm_cmd_done) begin
          ack_d   = 1'b1;
          state_d = next_decision(seq_bus.stall_fetch, 1'b0,
                                  seq_bus.cmd_is_valid[1]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and status registers; reset abandons any command without an ack.
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign seq_bus.fetch                = (state_q == FETCH);
  assign seq_bus.ecc_fetch_error_addr = (state_q == ECC_FETCH);
  assign seq_bus.current_valid        = slot_busy;
  assign seq_bus.ecc_active           = (state_q == ECC_ACTIVE);
  assign seq_bus.ecc_err_ack          = ack_q;
  assign seq_bus.err_unexpected_done  = err_q;
  assign seq_bus.fetch_count          = cnt_q;
  assign seq_bus.cmd_count =
    CMD_CNT_W'(popcount(POP_MAX_W'(seq_bus.cmd_is_valid)));

endmodule

// File: tb/tb_alt_ddrx_fetch_sequencer.sv
// Randomized + directed bench for the fetch sequencer, checked against a
// slot/load-level reference model.
module tb_alt_ddrx_fetch_sequencer;

  localparam int DEPTH = 8;
  localparam int CW    = 8;   // narrow counter so the wrap is reachable quickly

  localparam int K_NONE = 0;
  localparam int K_NORM = 1;
  localparam int K_ECC  = 2;

  logic ctl_clk;
  logic ctl_reset_n;

  alt_ddrx_fetch_sequencer_if #(.CTL_CMD_QUEUE_DEPTH(DEPTH), .CNT_WIDTH(CW)) bus_if ();

  alt_ddrx_fetch_sequencer #(.CTL_CMD_QUEUE_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .ctl_clk     (ctl_clk),
    .ctl_reset_n (ctl_reset_n),
    .seq_bus     (bus_if.slave)
  );

  initial ctl_clk = 1'b0;
  always #5 ctl_clk = ~ctl_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what is being loaded this cycle, what the slot holds.
  int m_load;
  int m_slot;
  bit m_ack;
  bit m_sticky;
  int m_fetches;

  bit ecc_hold;
  bit last_ack;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_load = K_NONE; m_slot = K_NONE; m_ack = 0; m_sticky = 0; m_fetches = 0;
    ecc_hold = 0; last_ack = 0;
  endtask

  function automatic int pick(input logic [8:0] v, input bit s, input bit e_ok);
    if (s) return K_NONE;
    if (e_ok) return K_ECC;
    if (v[1]) return K_NORM;
    return K_NONE;
  endfunction

  // Drive one cycle of inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic [8:0] v, input bit d, input bit s, input bit e);
    int n_load;
    bit n_ack;
    bus_if.cmd_is_valid = v;
    bus_if.sm_cmd_done  = d;
    bus_if.stall_fetch  = s;
    bus_if.ecc_err_req  = e;
    @(negedge ctl_clk);
    check_eq("fetch",      32'(bus_if.fetch),                32'(m_load == K_NORM));
    check_eq("ecc_fetch",  32'(bus_if.ecc_fetch_error_addr), 32'(m_load == K_ECC));
    check_eq("cur_valid",  32'(bus_if.current_valid),        32'(m_slot != K_NONE));
    check_eq("ecc_active", 32'(bus_if.ecc_active),           32'(m_slot == K_ECC));
    check_eq("ecc_ack",    32'(bus_if.ecc_err_ack),          32'(m_ack));
    check_eq("err_sticky", 32'(bus_if.err_unexpected_done),  32'(m_sticky));
    check_eq("fetch_cnt",  32'(bus_if.fetch_count),          32'(m_fetches % (1 << CW)));
    check_eq("cmd_count",  32'(bus_if.cmd_count),            32'($countones(v)));
    if (m_load != K_NONE || m_ack)
      $display("txn t=%0t load=%0d ack=%0b fetches=%0d", $time, m_load, m_ack, m_fetches);
    last_ack = m_ack;
    n_load = m_load;
    n_ack  = 0;
    if (d && m_slot == K_NONE) m_sticky = 1;
    if (m_load != K_NONE) begin
      if (m_load == K_NORM) m_fetches++;
      m_slot = m_load;
      n_load = K_NONE;
    end else if (m_slot == K_NONE) begin
      n_load = pick(v, s, e && !m_ack);
    end else if (d) begin
      n_ack  = (m_slot == K_ECC);
      n_load = pick(v, s, e && m_slot == K_NORM && !m_ack);
      m_slot = K_NONE;
    end
    m_load = n_load;
    m_ack  = n_ack;
    @(posedge ctl_clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_fetch"}, 32'(bus_if.fetch), 0);
    check_eq({tag, "_eccf"},  32'(bus_if.ecc_fetch_error_addr), 0);
    check_eq({tag, "_ack"},   32'(bus_if.ecc_err_ack), 0);
    check_eq({tag, "_cv"},    32'(bus_if.current_valid), 0);
    check_eq({tag, "_ea"},    32'(bus_if.ecc_active), 0);
    check_eq({tag, "_err"},   32'(bus_if.err_unexpected_done), 0);
    check_eq({tag, "_cnt"},   32'(bus_if.fetch_count), 0);
  endtask

  // Asynchronous reset applied between clock edges.
  task automatic do_reset(input string tag);
    bus_if.cmd_is_valid = '0;
    bus_if.sm_cmd_done  = 0;
    bus_if.stall_fetch  = 0;
    bus_if.ecc_err_req  = 0;
    ctl_reset_n = 0;
    #1;
    check_zero(tag);
    model_reset();
    @(posedge ctl_clk);
    #1;
    ctl_reset_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] v;
    bit d, s;
    bus_if.cmd_is_valid = '0;
    bus_if.sm_cmd_done  = 0;
    bus_if.stall_fetch  = 0;
    bus_if.ecc_err_req  = 0;
    ctl_reset_n = 0;
    model_reset();
    @(posedge ctl_clk);
    #1;
    check_zero("por");
    @(posedge ctl_clk);
    #1;
    ctl_reset_n = 1;

    // First fetch after reset.
    step(9'b0_0000_0010, 0, 0, 0);
    step(9'b0_0000_0010, 0, 0, 0);
    step(9'b0_0000_0010, 0, 0, 0);
    check_eq("tp1_cv",  32'(bus_if.current_valid), 1);
    check_eq("tp1_cnt", 32'(bus_if.fetch_count), 1);

    // Done with next entry valid: fetch one cycle later, back-to-back.
    step(9'b0_0000_0010, 1, 0, 0);
    check_eq("tp2_fetch", 32'(bus_if.fetch), 1);
    check_eq("tp2_cv0",   32'(bus_if.current_valid), 0);
    step(9'b0_0000_0010, 0, 0, 0);
    check_eq("tp2_cv1",   32'(bus_if.current_valid), 1);
    step(9'b0_0000_0010, 1, 0, 0);
    step(9'b0_0000_0010, 0, 0, 0);

    // ECC insertion at a done, then ack plus normal fetch.
    step(9'b0_0000_0010, 1, 0, 1);
    check_eq("tp3_eccf",  32'(bus_if.ecc_fetch_error_addr), 1);
    check_eq("tp3_nof",   32'(bus_if.fetch), 0);
    step(9'b0_0000_0010, 0, 0, 1);
    check_eq("tp3_ea",    32'(bus_if.ecc_active), 1);
    step(9'b0_0000_0010, 0, 0, 1);
    step(9'b0_0000_0010, 1, 0, 1);
    check_eq("tp3_ack",   32'(bus_if.ecc_err_ack), 1);
    check_eq("tp3_fetch", 32'(bus_if.fetch), 1);
    step(9'b0_0000_0010, 0, 0, 0);
    check_eq("tp3_ack0",  32'(bus_if.ecc_err_ack), 0);

    // Stall at done: idle, then fetch once stall drops.
    step(9'b0_0000_0010, 1, 1, 0);
    check_eq("tp4_nof",   32'(bus_if.fetch), 0);
    step(9'b0_0000_0010, 0, 1, 0);
    check_eq("tp4_nof2",  32'(bus_if.fetch), 0);
    step(9'b0_0000_0010, 0, 0, 0);
    check_eq("tp4_fetch", 32'(bus_if.fetch), 1);
    step(9'b0, 0, 0, 0);
    step(9'b0, 1, 0, 0);

    // Unexpected done in IDLE sets the sticky flag.
    step(9'b0, 1, 0, 0);
    check_eq("tp5_err", 32'(bus_if.err_unexpected_done), 1);
    check_eq("tp5_cv",  32'(bus_if.current_valid), 0);
    step(9'b1_1111_1101, 0, 0, 0);
    check_eq("tp5_err_hold", 32'(bus_if.err_unexpected_done), 1);
    do_reset("tp5_rst");

    // Reset during ECC_ACTIVE: no ack afterwards.
    step(9'b0, 0, 0, 1);
    step(9'b0, 0, 0, 1);
    step(9'b0, 0, 0, 1);
    check_eq("tp6_ea", 32'(bus_if.ecc_active), 1);
    do_reset("tp6_rst");
    step(9'b0, 0, 0, 0);
    check_eq("tp6_noack", 32'(bus_if.ecc_err_ack), 0);
    step(9'b1_1111_1111, 0, 1, 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset("rnd_rst");
      end else begin
        v = 9'($urandom);
        v[1] = ($urandom_range(0, 3) != 0);
        if (m_slot != K_NONE) d = ($urandom_range(0, 2) == 0);
        else d = ($urandom_range(0, 40) == 0);
        s = ($urandom_range(0, 7) == 0);
        if (last_ack) ecc_hold = 0;
        else if (!ecc_hold && $urandom_range(0, 15) == 0) ecc_hold = 1;
        step(v, d, s, ecc_hold);
      end
    end

    // Counter wrap: 2^CW fetches bring fetch_count back to 0.
    do_reset("wrap_rst");
    for (int i = 0; i < 2000 && m_fetches < (1 << CW); i++) begin
      step(9'h1FF, m_slot != K_NONE, 0, 0);
    end
    check_eq("wrap_reached", 32'(m_fetches), 32'(1 << CW));
    check_eq("wrap_zero", 32'(bus_if.fetch_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alt_ddrx_fetch_sequencer.md
# alt_ddrx_fetch_sequencer

Sequences command-queue fetches for the DDRx controller. It decides when the current command slot is retired and refilled (`fetch`), and when an ECC error-address command is inserted (`ecc_fetch_error_addr`). It drives the fetch and current-valid timing that the lookahead cache block expects. It sits between the command queue, the issue state machine and the ECC block.

## Interface
Parameters:
- CTL_CMD_QUEUE_DEPTH, 8, number of queued entries behind the current slot
- CNT_WIDTH, 16, width of the wrapping fetch counter

Ports:
- ctl_clk  in  1  controller clock
- ctl_reset_n  in  1  reset; asynchronous, active-low; clock ctl_clk
- cmd_is_valid  in  CTL_CMD_QUEUE_DEPTH+1  per-slot valid; bit 0 = current slot, bit 1 = next entry
- sm_cmd_done  in  1  one-cycle pulse: issue state machine finished the current command
- stall_fetch  in  1  level; blocks all new fetches (refresh, power-down, self-refresh)
- ecc_err_req  in  1  level; ECC requests an error-address command; held until ack
- fetch  out  1  one-cycle pulse: advance queue, slot 1 moves into slot 0
- ecc_fetch_error_addr  out  1  one-cycle pulse: load ECC error address into current slot
- ecc_err_ack  out  1  one-cycle pulse: ECC command completed
- current_valid  out  1  current slot holds a stable command
- ecc_active  out  1  current command is the ECC error-address command
- cmd_count  out  $clog2(CTL_CMD_QUEUE_DEPTH+2)  popcount of cmd_is_valid (combinational)
- fetch_count  out  CNT_WIDTH  number of fetch pulses, wraps at 2^CNT_WIDTH
- err_unexpected_done  out  1  sticky; sm_cmd_done seen outside ACTIVE/ECC_ACTIVE

## Operation
- Moore FSM with states IDLE, FETCH, ACTIVE, ECC_FETCH, ECC_ACTIVE. All outputs except cmd_count are decoded from registered state or registers.
- Outputs per state:
  - FETCH: fetch=1.
  - ECC_FETCH: ecc_fetch_error_addr=1.
  - ACTIVE: current_valid=1.
  - ECC_ACTIVE: current_valid=1, ecc_active=1.
  - current_valid=0 in IDLE, FETCH and ECC_FETCH.
- IDLE transitions, in priority order:
  - stall_fetch → IDLE.
  - ecc_err_req → ECC_FETCH.
  - cmd_is_valid[1] → FETCH.
  - otherwise stay in IDLE.
- FETCH → ACTIVE unconditionally. ECC_FETCH → ECC_ACTIVE unconditionally.
- ACTIVE: hold until sm_cmd_done. On sm_cmd_done, apply the "next" decision:
  - stall_fetch → IDLE.
  - ecc_err_req → ECC_FETCH.
  - cmd_is_valid[1] → FETCH.
  - otherwise → IDLE.
- ECC_ACTIVE: on sm_cmd_done, pulse ecc_err_ack on the next cycle. Then take the "next" decision with ecc_err_req ignored for that cycle.
- sm_cmd_done in IDLE, FETCH or ECC_FETCH: ignored for sequencing; sets err_unexpected_done (cleared only by reset).
- ecc_err_req arriving mid-command: not serviced until the current command completes. ECC has priority over normal fetch at every decision point.
- fetch_count increments once per cycle in FETCH.

## Timing
- Reset: state IDLE; fetch, ecc_fetch_error_addr, ecc_err_ack, current_valid, ecc_active, err_unexpected_done all 0; fetch_count 0.
- No fetch in the first cycle after reset release. Reset mid-command abandons the command without an ack.
- Latencies:
  - sm_cmd_done at cycle N → fetch (or ecc_fetch_error_addr) at N+1 → current_valid=1 at N+2.
  - IDLE with cmd_is_valid[1] at N → fetch at N+1.
- Minimum spacing between any two fetch/ecc_fetch_error_addr pulses is 2 cycles.
- fetch and ecc_fetch_error_addr are never high together. current_valid is always 0 while either is high.
- Simultaneous events:
  - sm_cmd_done with stall_fetch → IDLE.
  - stall_fetch rising while in FETCH or ECC_FETCH does not cancel the pulse already issued.
- cmd_count tracks cmd_is_valid with zero latency; all-ones gives CTL_CMD_QUEUE_DEPTH+1.
- fetch_count wraps from all-ones to 0.

## Structure
- Shared package alt_ddrx_fetch_pkg holds:
  - the state enumeration (IDLE, FETCH, ACTIVE, ECC_FETCH, ECC_ACTIVE);
  - a popcount function reused by the queue block.
- Single flat module; no sub-module. The FSM, counter and sticky flag are each small.

## Test plan
- Reset, then cmd_is_valid=9'b0_0000_0010 → fetch at +1, current_valid at +2, fetch_count=1.
- In ACTIVE, sm_cmd_done with cmd_is_valid[1]=1 → fetch exactly 1 cycle later; current_valid 1→0→1; back-to-back commands keep 2-cycle fetch spacing.
- ecc_err_req=1 with sm_cmd_done in ACTIVE → ecc_fetch_error_addr at +1, ecc_active=1 at +2; later done → ecc_err_ack at +1, then fetch if cmd_is_valid[1].
- stall_fetch=1 at sm_cmd_done → IDLE, no fetch; drop stall → fetch on the next cycle.
- sm_cmd_done pulsed in IDLE → err_unexpected_done=1 and stays 1 until ctl_reset_n asserted; no state change.
- Reset asserted during ECC_ACTIVE → all outputs 0 immediately, no ecc_err_ack; 65536 fetches → fetch_count wraps to 0.
